// File: rtl/alu_driver.sv
// alu_driver: request/response wrapper that launches a multi-cycle ALU and aborts a stalled operation on timeout
module alu_driver #(
    parameter int N       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [N-1:0] req_a_i,
    input  logic [N-1:0] req_b_i,
    output logic         start_o,
    input  logic         finished_i,
    output logic [N-1:0] a_o,
    output logic [N-1:0] b_o,
    input  logic [N-1:0] y_i,
    input  logic [N-1:0] x_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [N-1:0] rsp_y_o,
    output logic [N-1:0] rsp_x_o,
    output logic         rsp_timeout_o,
    output logic [7:0]   op_count_o
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d, y_q, y_d, x_q, x_d;
    logic          to_q, to_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    ops_q, ops_d;

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            x_q     <= '0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            x_q     <= x_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            ops_q   <= ops_d;
        end
    end

    // Next state: finished wins over the timeout on the last wait cycle; counter stops at LAST
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        x_d     = x_q;
        to_d    = to_q;
        cnt_d   = cnt_q;
        ops_d   = ops_q;
        unique case (state_q)
            IDLE: if (req_valid_i) begin
                a_d     = req_a_i;
                b_d     = req_b_i;
                state_d = ISSUE;
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (finished_i) begin
                y_d     = y_i;
                x_d     = x_i;
                to_d    = 1'b0;
                state_d = RESPOND;
            end else if (cnt_q == LAST) begin
                y_d     = '0;
                x_d     = '0;
                to_d    = 1'b1;
                state_d = RESPOND;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            RESPOND: if (rsp_ready_i) begin
                ops_d   = to_q ? ops_q : ops_q + 8'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o   = state_q == IDLE;
    assign start_o       = state_q == ISSUE;
    assign rsp_valid_o   = state_q == RESPOND;
    assign a_o           = a_q;
    assign b_o           = b_q;
    assign rsp_y_o       = y_q;
    assign rsp_x_o       = x_q;
    assign rsp_timeout_o = to_q;
    assign op_count_o    = ops_q;
endmodule

// File: tb/tb_alu_driver.sv
// tb_alu_driver: directed scoreboard bench for alu_driver with a delay-programmable ALU model
module tb_alu_driver;
    localparam int N  = 4;
    localparam int TO = 4;

    typedef struct {
        logic [N-1:0] y;
        logic [N-1:0] x;
        logic         to;
    } exp_t;

    logic         clk_i = 1'b0, rst_i = 1'b1;
    logic         req_valid_i, req_ready_o, start_o, finished_i;
    logic         rsp_valid_o, rsp_ready_i, rsp_timeout_o;
    logic [N-1:0] req_a_i, req_b_i, a_o, b_o, y_i, x_i, rsp_y_o, rsp_x_o;
    logic [7:0]   op_count_o;

    exp_t       sb[$];
    exp_t       mon_e, st_e;
    int         checks = 0, fails = 0, starts = 0;
    int         alu_delay = 0, alu_cnt = -1;
    logic       alu_fin = 1'b0, man_fin = 1'b0;
    logic [7:0] exp_ops = 8'd0;
    int         lat, s0, w;

    alu_driver #(.N(N), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i),
        .start_o(start_o), .finished_i(finished_i),
        .a_o(a_o), .b_o(b_o), .y_i(y_i), .x_i(x_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_y_o(rsp_y_o), .rsp_x_o(rsp_x_o),
        .rsp_timeout_o(rsp_timeout_o), .op_count_o(op_count_o)
    );

    initial forever #5 clk_i = ~clk_i;

    // ALU model: Y = A+B, X = A&B, finished raised alu_delay cycles after start (0 = never)
    assign y_i        = N'(a_o + b_o);
    assign x_i        = a_o & b_o;
    assign finished_i = alu_fin | man_fin;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (start_o) begin
            starts++;
            alu_cnt = alu_delay > 0 ? alu_delay : -1;
        end else if (alu_cnt >= 0) begin
            alu_cnt--;
        end
        alu_fin = alu_cnt == 0;
    end

    // Response monitor: pops the scoreboard on every accepted response
    always @(negedge clk_i) begin
        #2;
        if (!rst_i && rsp_valid_o && rsp_ready_i) begin
            if (sb.size() == 0) chk("sb_empty", sb.size(), 1);
            else begin
                mon_e = sb.pop_front();
                chk("rsp_y", rsp_y_o, mon_e.y);
                chk("rsp_x", rsp_x_o, mon_e.x);
                chk("rsp_timeout", rsp_timeout_o, mon_e.to);
                if (!mon_e.to) exp_ops++;
            end
        end
    end

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int d, output int l);
        int   k;
        exp_t e;
        k = 0;
        while (!req_ready_o && k < 50) begin
            @(negedge clk_i);
            k++;
        end
        alu_delay   = d;
        req_valid_i = 1'b1;
        req_a_i     = a;
        req_b_i     = b;
        e.to = d < 1 || d > TO;
        e.y  = e.to ? '0 : N'(a + b);
        e.x  = e.to ? '0 : a & b;
        sb.push_back(e);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        l = 1;
        while (!rsp_valid_o && l < 50) begin
            @(negedge clk_i);
            l++;
        end
        if (!rsp_valid_o) chk("rsp_wait", rsp_valid_o, 1);
        @(negedge clk_i);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, req_ready_o, 1);
        chk({tag, "_start"}, start_o, 0);
        chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
        chk({tag, "_rsp_timeout"}, rsp_timeout_o, 0);
        chk({tag, "_a"}, a_o, 0);
        chk({tag, "_b"}, b_o, 0);
        chk({tag, "_rsp_y"}, rsp_y_o, 0);
        chk({tag, "_rsp_x"}, rsp_x_o, 0);
        chk({tag, "_op_count"}, op_count_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid_i = 1'b0;
        req_a_i     = '0;
        req_b_i     = '0;
        rsp_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk_reset("rst");
        rst_i = 1'b0;
        @(negedge clk_i);

        s0 = starts;
        run_op(4'd6, 4'd3, 2, lat);
        chk("lat_d2", lat, 4);
        chk("op_count_1", op_count_o, 1);
        chk("starts_1", starts - s0, 1);
        chk("a_hold", a_o, 6);
        chk("b_hold", b_o, 3);

        run_op(4'd2, 4'd5, 1, lat);
        chk("lat_min", lat, 3);

        run_op(4'd5, 4'd7, 0, lat);
        chk("lat_timeout", lat, 6);
        chk("op_count_to", op_count_o, 2);

        run_op(4'd9, 4'd4, 4, lat);
        chk("lat_race", lat, 6);
        chk("op_count_race", op_count_o, 3);

        run_op(4'd1, 4'd1, 5, lat);
        chk("lat_late", lat, 6);
        chk("op_count_late", op_count_o, exp_ops);

        rsp_ready_i = 1'b0;
        alu_delay   = 2;
        req_valid_i = 1'b1;
        req_a_i     = 4'd7;
        req_b_i     = 4'd1;
        st_e.y  = 4'd8;
        st_e.x  = 4'd1;
        st_e.to = 1'b0;
        sb.push_back(st_e);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        w = 0;
        while (!rsp_valid_o && w < 50) begin
            @(negedge clk_i);
            w++;
        end
        s0 = starts;
        req_valid_i = 1'b1;
        req_a_i     = 4'd15;
        req_b_i     = 4'd15;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("bp_valid", rsp_valid_o, 1);
            chk("bp_y", rsp_y_o, 8);
            chk("bp_x", rsp_x_o, 1);
            chk("bp_req_ready", req_ready_o, 0);
            chk("bp_a", a_o, 7);
        end
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("bp_idle", req_ready_o, 1);
        chk("bp_no_start", starts - s0, 0);
        chk("bp_op_count", op_count_o, exp_ops);

        alu_delay   = 0;
        req_valid_i = 1'b1;
        req_a_i     = 4'd3;
        req_b_i     = 4'd3;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk_reset("arst");
        exp_ops = 8'd0;
        @(negedge clk_i);
        rst_i   = 1'b0;
        man_fin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("post_rst_valid", rsp_valid_o, 0);
            chk("post_rst_ready", req_ready_o, 1);
        end
        man_fin = 1'b0;
        chk("post_rst_sb", sb.size(), 0);

        s0 = starts;
        for (int i = 0; i < 256; i++) run_op(4'(i), 4'(i >> 4), 1 + i % 3, lat);
        chk("wrap_starts", starts - s0, 256);
        chk("wrap_op_count", op_count_o, 0);
        chk("wrap_model", op_count_o, exp_ops);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
